// File: rtl/erosion_packer_if.sv
// AXI4-Stream style output channel of the erosion packer: 32-bit packed
// pixel word with line (tlast) and frame (tuser) markers.
`timescale 1ns/1ps
interface erosion_packer_if;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic        tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/erosion_packer.sv
// erosion_packer: packs 8-bit eroded pixels four to a 32-bit word (pixel 0 in
// the low byte), tags words with end-of-line / start-of-frame markers and
// buffers them in a small FIFO feeding a valid/ready stream.
// Optional feature: define EROSION_PACKER_OVF_CNT_EN to add the ovf_cnt
// output, a saturating count of words dropped because the FIFO was full.
`timescale 1ns/1ps
module erosion_packer #(
   parameter int LINE_PIX    = 752,
   parameter int FRAME_LINES = 480,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic              s_axi_aclk,
   input  logic              s_axi_aresetn,
   input  logic              sensor_state,
   input  logic              erosion_valid,
   input  logic [7:0]        erosion_dout,
   erosion_packer_if.master  m_axis,
   output logic              frame_done,
   output logic              overflow
`ifdef EROSION_PACKER_OVF_CNT_EN
   ,
   output logic [15:0]       ovf_cnt
`endif
);

   localparam int PW = $clog2(LINE_PIX);
   localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   // Pixel position and partial-word state
   logic [1:0]    lane_reg;
   logic [PW-1:0] pix_reg;
   logic [LW-1:0] line_reg;
   logic [31:0]   pack_reg;

   // Formed word waiting one cycle before entering the FIFO
   logic          stage_valid_reg;
   logic [31:0]   stage_data_reg;
   logic          stage_last_reg;
   logic          stage_user_reg;
   logic          frame_done_reg;
   logic          overflow_reg;

   // FIFO storage: {tuser, tlast, tdata}
   logic [33:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;

   logic          accept;
   logic          line_end;
   logic          frame_end;
   logic          word_done;
   logic [7:0]    lane_byte [4];
   logic [31:0]   word_next;
   logic          pop;
   logic          full;
   logic          do_push;
   logic          drop;
   logic [33:0]   head;

   assign accept    = sensor_state && erosion_valid;
   assign line_end  = (pix_reg == PW'(LINE_PIX - 1));
   assign frame_end = line_end && (line_reg == LW'(FRAME_LINES - 1));
   assign word_done = accept && ((lane_reg == 2'd3) || line_end);

   // Each lane takes the new pixel when selected; lanes past the final pixel
   // of a short line are padded with 8'hFF.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_byte[gi] = (lane_reg == 2'(gi))               ? erosion_dout :
                                (line_end && (lane_reg < 2'(gi)))  ? 8'hFF :
                                pack_reg[8*gi +: 8];
      end
   endgenerate

   assign word_next = {lane_byte[3], lane_byte[2], lane_byte[1], lane_byte[0]};

   // Lane / pixel / line counters and pack register; sensor_state low flushes them
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         lane_reg <= '0;
         pix_reg  <= '0;
         line_reg <= '0;
         pack_reg <= '0;
      end else if (!sensor_state) begin
         lane_reg <= '0;
         pix_reg  <= '0;
         line_reg <= '0;
         pack_reg <= '0;
      end else if (accept) begin
         lane_reg <= word_done ? 2'd0 : lane_reg + 2'd1;
         pack_reg <= word_done ? 32'd0 : word_next;
         if (line_end) begin
            pix_reg  <= '0;
            line_reg <= frame_end ? '0 : line_reg + LW'(1);
         end else begin
            pix_reg <= pix_reg + PW'(1);
         end
      end
   end

   // Capture the completed word with its tags; frame_done pulses one cycle later
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         stage_valid_reg <= 1'b0;
         stage_data_reg  <= '0;
         stage_last_reg  <= 1'b0;
         stage_user_reg  <= 1'b0;
         frame_done_reg  <= 1'b0;
      end else begin
         stage_valid_reg <= word_done;
         frame_done_reg  <= accept && frame_end;
         if (word_done) begin
            stage_data_reg <= word_next;
            stage_last_reg <= line_end;
            // Words start on 4-pixel boundaries, so pixel 0 is inside this
            // word exactly when the pixel index equals the lane index.
            stage_user_reg <= (line_reg == '0) && (pix_reg == PW'(lane_reg));
         end
      end
   end

   assign pop     = m_axis.tvalid && m_axis.tready;
   assign full    = (count_reg == CW'(FIFO_DEPTH));
   assign do_push = stage_valid_reg && (!full || pop);
   assign drop    = stage_valid_reg && full && !pop;

   // FIFO storage write, kept free of reset so it maps onto RAM
   always_ff @(posedge s_axi_aclk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= {stage_user_reg, stage_last_reg, stage_data_reg};
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
         if (drop) overflow_reg <= 1'b1;
      end
   end

`ifdef EROSION_PACKER_OVF_CNT_EN
   logic [15:0] ovf_cnt_reg;

   // Saturating count of dropped words
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         ovf_cnt_reg <= '0;
      end else if (drop && (ovf_cnt_reg != 16'hFFFF)) begin
         ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
      end
   end

   assign ovf_cnt = ovf_cnt_reg;
`endif

   // Head entry is shown only while the FIFO holds data, so outputs read 0 when empty
   assign head          = mem[rd_ptr_reg];
   assign m_axis.tvalid = (count_reg != '0);
   assign m_axis.tdata  = m_axis.tvalid ? head[31:0] : 32'd0;
   assign m_axis.tlast  = m_axis.tvalid && head[32];
   assign m_axis.tuser  = m_axis.tvalid && head[33];
   assign frame_done    = frame_done_reg;
   assign overflow      = overflow_reg;

endmodule

// File: tb/tb_erosion_packer.sv
// Self-checking bench for erosion_packer using short lines/frames
// (10 pixels x 3 lines) so partial-word padding and frame wrap occur often.
`timescale 1ns/1ps
module tb_erosion_packer;
   localparam int LP = 10;
   localparam int FL = 3;
   localparam int FD = 8;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       sensor_state = 1'b0;
   logic       erosion_valid = 1'b0;
   logic [7:0] erosion_dout = 8'd0;
   logic       frame_done;
   logic       overflow;
`ifdef EROSION_PACKER_OVF_CNT_EN
   logic [15:0] ovf_cnt;
`endif

   erosion_packer_if axis();

   erosion_packer #(.LINE_PIX(LP), .FRAME_LINES(FL), .FIFO_DEPTH(FD)) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (resetn),
      .sensor_state  (sensor_state),
      .erosion_valid (erosion_valid),
      .erosion_dout  (erosion_dout),
      .m_axis        (axis.master),
      .frame_done    (frame_done),
      .overflow      (overflow)
`ifdef EROSION_PACKER_OVF_CNT_EN
      ,
      .ovf_cnt       (ovf_cnt)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [33:0] expq [$];
   logic [7:0]  cur [$];
   int pix = 0;
   int line = 0;
   int frames_exp = 0;
   int frames_seen = 0;
   bit rand_ready = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: collect pixels into a word until 4 are held or the line ends.
   task automatic model_pixel(input logic [7:0] p);
      logic [31:0] w;
      int first;
      cur.push_back(p);
      if (cur.size() == 4 || pix == LP - 1) begin
         w = '1;
         for (int i = 0; i < cur.size(); i++) w[8*i +: 8] = cur[i];
         first = pix - cur.size() + 1;
         expq.push_back({(line == 0 && first == 0), (pix == LP - 1), w});
         cur.delete();
      end
      if (pix == LP - 1) begin
         pix = 0;
         if (line == FL - 1) begin
            line = 0;
            frames_exp++;
         end else begin
            line++;
         end
      end else begin
         pix++;
      end
   endtask

   task automatic model_flush();
      cur.delete();
      pix = 0;
      line = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) axis.tready = ($urandom_range(3) != 0);
   endtask

   task automatic drive_pixel(input logic [7:0] p);
      step();
      erosion_valid = 1'b1;
      erosion_dout  = p;
      model_pixel(p);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         erosion_valid = 1'b0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && expq.size() != 0; i++) idle(1);
      check("drain_done", expq.size(), 0);
      idle(2);
      @(negedge clk);
      check("fifo_empty_tvalid", axis.tvalid, 0);
   endtask

   // Output monitor / scoreboard
   initial begin
      bit prev_hold = 0;
      bit prev_fd = 0;
      logic [31:0] prev_data = '0;
      logic [33:0] e;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            prev_hold = 0;
            prev_fd = 0;
         end else begin
            if (prev_hold) begin
               check("hold_tvalid", axis.tvalid, 1);
               check("hold_tdata", axis.tdata, prev_data);
            end
            if (frame_done) begin
               frames_seen++;
               check("frame_done_width", prev_fd, 0);
            end
            prev_fd = frame_done;
            if (axis.tvalid && axis.tready) begin
               check("word_pending", 32'(expq.size() > 0), 1);
               if (expq.size() > 0) begin
                  e = expq.pop_front();
                  check("tdata", axis.tdata, e[31:0]);
                  check("tlast", axis.tlast, e[32]);
                  check("tuser", axis.tuser, e[33]);
                  $display("word %h last=%0d user=%0d", axis.tdata, axis.tlast, axis.tuser);
               end
            end
            prev_hold = axis.tvalid && !axis.tready;
            prev_data = axis.tdata;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      axis.tready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", axis.tvalid, 0);
      check("rst_tdata", axis.tdata, 0);
      check("rst_tlast", axis.tlast, 0);
      check("rst_tuser", axis.tuser, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overflow", overflow, 0);
      step();
      resetn = 1'b1;
      sensor_state = 1'b1;

      // Latency: word of 0x11..0x44 shows on tvalid two cycles after the 0x44 strobe
      drive_pixel(8'h11);
      drive_pixel(8'h22);
      drive_pixel(8'h33);
      drive_pixel(8'h44);
      idle(1);
      @(negedge clk);
      check("lat_tvalid_early", axis.tvalid, 0);
      @(negedge clk);
      check("lat_tvalid", axis.tvalid, 1);
      check("lat_tdata", axis.tdata, 32'h44332211);
      check("lat_tuser", axis.tuser, 1);
      check("lat_tlast", axis.tlast, 0);
      step();
      axis.tready = 1'b1;
      drain();

      // Randomized data, input gaps and backpressure
      rand_ready = 1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) idle(1);
         else drive_pixel(8'($urandom));
      end
      idle(1);
      drain();
      rand_ready = 0;
      axis.tready = 1'b1;
      check("no_overflow_random", overflow, 0);

      // sensor_state low mid-line drops the partial word and restarts at line 0
      drive_pixel(8'hA1);
      drive_pixel(8'hA2);
      drive_pixel(8'hA3);
      step();
      sensor_state = 1'b0;
      erosion_valid = 1'b1;
      erosion_dout = 8'hEE;
      model_flush();
      step();
      sensor_state = 1'b1;
      erosion_valid = 1'b0;
      for (int i = 0; i < 6; i++) drive_pixel(8'(8'hB0 + i));
      idle(1);
      drain();

      // Reset mid-line with words buffered abandons everything
      axis.tready = 1'b0;
      for (int i = 0; i < 6; i++) drive_pixel(8'(8'hC0 + i));
      idle(3);
      step();
      resetn = 1'b0;
      erosion_valid = 1'b0;
      expq.delete();
      model_flush();
      @(negedge clk);
      check("midrst_tvalid", axis.tvalid, 0);
      check("midrst_tdata", axis.tdata, 0);
      check("midrst_frame_done", frame_done, 0);
      idle(2);
      resetn = 1'b1;
      axis.tready = 1'b1;
      for (int i = 0; i < 4; i++) drive_pixel(8'(8'hD0 + i));
      idle(1);
      drain();

      // Overflow: 40 words with no downstream accept, FIFO keeps the first 8
      axis.tready = 1'b0;
      while (expq.size() < 40) drive_pixel(8'($urandom));
      idle(4);
      @(negedge clk);
      check("ovf_flag", overflow, 1);
      check("ovf_tvalid", axis.tvalid, 1);
`ifdef EROSION_PACKER_OVF_CNT_EN
      check("ovf_cnt", ovf_cnt, 32);
`endif
      while (expq.size() > FD) void'(expq.pop_back());
      step();
      axis.tready = 1'b1;
      drain();
      check("ovf_sticky", overflow, 1);
      check("frame_count", frames_seen, frames_exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
